// File: rtl/regfile_wb_queue_pkg.sv
// Shared register-file-side definitions for the write-back queue.
// Used by the queue itself and by anything that packs or unpacks its results.
package regfile_wb_queue_pkg;

  localparam int RF_XLEN  = 32;
  localparam int RF_AW    = 5;
  localparam int RF_NREGS = 32;

  typedef struct packed {
    logic [RF_AW-1:0]   rd;
    logic [RF_XLEN-1:0] data;
  } rf_wb_entry_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// Generic synchronous FIFO with occupancy count. Push is ignored when full and
// pop is ignored when empty; a same-edge push and pop leaves the count unchanged.
module rf_wb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 37,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // DEPTH is a power of two, so plain increments wrap the pointers.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/regfile_wb_queue.sv
// Write-side driver for the register file: buffers results in order, drains one
// per cycle onto the write port, and tracks destination registers with pending writes.
module regfile_wb_queue
  import regfile_wb_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = RF_XLEN,
  parameter int AW    = RF_AW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   issue_valid,
  input  logic [AW-1:0]          issue_rd,
  input  logic [AW-1:0]          rs1_addr,
  input  logic [AW-1:0]          rs2_addr,
  output logic                   rs1_busy,
  output logic                   rs2_busy,
  // Result handshake: a transfer happens on an edge where res_valid && res_ready.
  // res_ready depends only on registered occupancy, never on a same-cycle drain.
  input  logic                   res_valid,
  output logic                   res_ready,
  input  logic [AW-1:0]          res_rd,
  input  logic [XLEN-1:0]        res_data,
  input  logic                   wb_hold,
  output logic                   write_ena,
  output logic [AW-1:0]          write_reg_addr,
  output logic [XLEN-1:0]        data_in,
  output logic [$clog2(DEPTH):0] count
);

  localparam int NREGS = 2 ** AW;
  localparam int EW    = AW + XLEN;

  logic            fifo_full, fifo_empty;
  logic            push, pop;
  logic [EW-1:0]   head;
  logic            write_ena_q;
  logic [AW-1:0]   write_reg_addr_q;
  logic [XLEN-1:0] data_in_q;
  logic [NREGS-1:1] busy_q, busy_d;
  logic [NREGS-1:0] busy_vec;

  assign res_ready = !fifo_full;
  // x0 results complete the handshake but never reach the register file.
  assign push      = res_valid && res_ready && (res_rd != '0);
  assign pop       = !fifo_empty && !wb_hold;

  rf_wb_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(EW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .din_i   ({res_rd, res_data}),
    .pop_i   (pop),
    .dout_o  (head),
    .count_o (count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Set is applied after clear so a re-issue on the committing edge keeps the bit.
  always_comb begin
    for (int r = 1; r < NREGS; r++) begin
      busy_d[r] = busy_q[r];
      if (write_ena_q && write_reg_addr_q == AW'(r)) busy_d[r] = 1'b0;
      if (issue_valid && issue_rd == AW'(r))         busy_d[r] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_ena_q      <= 1'b0;
      write_reg_addr_q <= '0;
      data_in_q        <= '0;
      busy_q           <= '0;
    end else begin
      write_ena_q <= pop;
      if (pop) begin
        write_reg_addr_q <= head[EW-1:XLEN];
        data_in_q        <= head[XLEN-1:0];
      end
      busy_q <= busy_d;
    end
  end

  assign busy_vec       = {busy_q, 1'b0};
  assign rs1_busy       = busy_vec[rs1_addr];
  assign rs2_busy       = busy_vec[rs2_addr];
  assign write_ena      = write_ena_q;
  assign write_reg_addr = write_reg_addr_q;
  assign data_in        = data_in_q;

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed bench for regfile_wb_queue: expected writes are queued as results are
// driven and checked in order whenever the write port fires.
module tb_regfile_wb_queue;
  import regfile_wb_queue_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               issue_valid = 1'b0;
  logic [RF_AW-1:0]   issue_rd = '0;
  logic [RF_AW-1:0]   rs1_addr = '0;
  logic [RF_AW-1:0]   rs2_addr = '0;
  logic               rs1_busy, rs2_busy;
  logic               res_valid = 1'b0;
  logic               res_ready;
  logic [RF_AW-1:0]   res_rd = '0;
  logic [RF_XLEN-1:0] res_data = '0;
  logic               wb_hold = 1'b0;
  logic               write_ena;
  logic [RF_AW-1:0]   write_reg_addr;
  logic [RF_XLEN-1:0] data_in;
  logic [2:0]         count;

  int errors = 0;
  int checks = 0;
  rf_wb_entry_t exp_q[$];

  regfile_wb_queue #(.DEPTH(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .issue_valid    (issue_valid),
    .issue_rd       (issue_rd),
    .rs1_addr       (rs1_addr),
    .rs2_addr       (rs2_addr),
    .rs1_busy       (rs1_busy),
    .rs2_busy       (rs2_busy),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_rd         (res_rd),
    .res_data       (res_data),
    .wb_hold        (wb_hold),
    .write_ena      (write_ena),
    .write_reg_addr (write_reg_addr),
    .data_in        (data_in),
    .count          (count)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_res(input logic [RF_AW-1:0] rd, input logic [RF_XLEN-1:0] data);
    rf_wb_entry_t e;
    res_valid = 1'b1;
    res_rd    = rd;
    res_data  = data;
    e.rd      = rd;
    e.data    = data;
    if (rd != '0) exp_q.push_back(e);
  endtask

  task automatic idle_res();
    res_valid = 1'b0;
    res_rd    = '0;
    res_data  = '0;
  endtask

  // Scoreboard: every write-port pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && write_ena) begin
      if (exp_q.size() == 0) begin
        chk("wb_unexpected_write", write_ena, 1'b0);
      end else begin
        rf_wb_entry_t e;
        e = exp_q.pop_front();
        chk("wb_addr", write_reg_addr, e.rd);
        chk("wb_data", data_in, e.data);
      end
    end
  end

  initial begin
    // Reset state
    #12;
    chk("rst_count", count, 0);
    chk("rst_write_ena", write_ena, 0);
    chk("rst_addr", write_reg_addr, 0);
    chk("rst_data", data_in, 0);
    chk("rst_ready", res_ready, 1);
    chk("rst_rs1_busy", rs1_busy, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Reset mid-traffic
    wb_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_res(RF_AW'(i + 1), $urandom);
      tick();
    end
    idle_res();
    issue_valid = 1'b1; issue_rd = 5; rs1_addr = 5;
    tick();
    issue_valid = 1'b0;
    chk("mid_count3", count, 3);
    chk("mid_busy5", rs1_busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_write_ena", write_ena, 0);
    chk("mid_rst_busy5", rs1_busy, 0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    wb_hold = 1'b0;
    tick();
    tick();
    chk("post_rst_no_write", write_ena, 0);
    chk("post_rst_count", count, 0);

    // Basic latency with scoreboard reservation
    issue_valid = 1'b1; issue_rd = 7; rs1_addr = 7; rs2_addr = 8;
    drive_res(7, 32'hDEADBEEF);
    tick();  // edge N
    issue_valid = 1'b0; idle_res();
    chk("lat_n_write_ena", write_ena, 0);
    chk("lat_n_count", count, 1);
    chk("lat_n_busy7", rs1_busy, 1);
    chk("lat_n_busy8", rs2_busy, 0);
    tick();  // edge N+1
    chk("lat_n1_write_ena", write_ena, 1);
    chk("lat_n1_addr", write_reg_addr, 7);
    chk("lat_n1_data", data_in, 32'hDEADBEEF);
    chk("lat_n1_busy7", rs1_busy, 1);
    tick();  // edge N+2
    chk("lat_n2_busy7", rs1_busy, 0);
    chk("lat_n2_write_ena", write_ena, 0);

    // Full and backpressure
    wb_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("full_ready_before_push", res_ready, 1);
      drive_res(RF_AW'($urandom_range(1, 31)), $urandom);
      tick();
    end
    chk("full_count", count, 4);
    chk("full_ready", res_ready, 0);
    res_valid = 1'b1; res_rd = 3; res_data = 32'h5555AAAA;
    tick();
    idle_res();
    chk("full_rejected_count", count, 4);
    wb_hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("drain_write_ena", write_ena, 1);
      chk("drain_count", count, 3 - i);
      chk("drain_ready", res_ready, 1);
    end
    tick();
    chk("drain_done_write_ena", write_ena, 0);

    // x0 handling
    rs1_addr = 0;
    chk("x0_ready", res_ready, 1);
    issue_valid = 1'b1; issue_rd = 0;
    drive_res(0, 32'h1234);
    tick();
    issue_valid = 1'b0; idle_res();
    chk("x0_count", count, 0);
    chk("x0_busy", rs1_busy, 0);
    tick();
    chk("x0_no_write", write_ena, 0);

    // Set/clear collision on x9
    rs1_addr = 9;
    issue_valid = 1'b1; issue_rd = 9;
    drive_res(9, 32'h0000_0900);
    tick();
    issue_valid = 1'b0; idle_res();
    tick();
    chk("coll_write_ena", write_ena, 1);
    chk("coll_addr", write_reg_addr, 9);
    issue_valid = 1'b1; issue_rd = 9;
    tick();  // edge M: commit and re-reserve
    issue_valid = 1'b0;
    chk("coll_busy9_kept", rs1_busy, 1);
    drive_res(9, 32'h0000_0901);
    tick();
    idle_res();
    tick();
    chk("coll2_busy9_pending", rs1_busy, 1);
    tick();
    chk("coll2_busy9_cleared", rs1_busy, 0);

    // Simultaneous push/pop across pointer wrap
    wb_hold = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive_res(RF_AW'($urandom_range(1, 31)), $urandom);
      tick();
    end
    chk("wrap_count_start", count, 2);
    wb_hold = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive_res(RF_AW'($urandom_range(1, 31)), $urandom);
      tick();
      chk("wrap_count", count, 2);
      chk("wrap_write_ena", write_ena, 1);
    end
    idle_res();
    tick();
    tick();
    chk("wrap_drained", count, 0);
    tick();
    chk("wrap_idle", write_ena, 0);
    chk("exp_q_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_wb_queue.md
Name: regfile_wb_queue

Overview:
- Write-side driver for the core's 32x32 register file. Execution results arrive on a valid/ready interface and are buffered in order in a small FIFO.
- Results drain one per cycle onto the register file write port (write_ena / write_reg_addr / data_in).
- Maintains a busy scoreboard of destination registers. Decode reserves a register at issue; the bit clears when its write commits, giving the hazard check for source operands.

Parameters:
- DEPTH, 4, FIFO entries (power of two, >= 2)
- XLEN, 32, data width
- AW, 5, register address width (32 registers)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous reset, active-low
- issue_valid  in  1  decode issues an instruction with a destination register
- issue_rd  in  AW  destination register to reserve
- rs1_addr  in  AW  source-operand query 1
- rs2_addr  in  AW  source-operand query 2
- rs1_busy  out  1  rs1_addr has a pending write
- rs2_busy  out  1  rs2_addr has a pending write
- res_valid  in  1  result offered
- res_ready  out  1  queue can accept a result
- res_rd  in  AW  result destination
- res_data  in  XLEN  result value
- wb_hold  in  1  suppress draining this cycle
- write_ena  out  1  register file write enable (registered)
- write_reg_addr  out  AW  register file write address (registered)
- data_in  out  XLEN  register file write data (registered)
- count  out  clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset: rst_n low asynchronously clears the FIFO pointers, count=0, all scoreboard bits, write_ena=0, write_reg_addr=0, data_in=0. rst_n low mid-operation discards all queued results and reservations.
- Accept:
  - res_ready = (count != DEPTH). Pure function of state; it does not look ahead to a same-cycle pop.
  - A result is accepted on an edge with res_valid && res_ready.
  - res_rd == 0: accepted but not enqueued (x0 results are dropped).
- Drain:
  - On each edge with count > 0 and !wb_hold, the head entry pops into the output registers and write_ena is set to 1 for the following cycle.
  - Otherwise write_ena is set to 0; write_reg_addr and data_in hold their values.
- Latency: a result accepted into an empty queue at edge N appears with write_ena=1 during the cycle after edge N+1. The register file commits it at edge N+2.
- Ordering: strictly FIFO. Same-edge push and pop is legal; count is unchanged in that case. Pointers wrap modulo DEPTH.
- Scoreboard: busy[1..31] flops; busy[0] is constant 0.
  - Set: issue_valid && issue_rd != 0 sets busy[issue_rd] on the edge.
  - Clear: write_ena && write_reg_addr != 0 clears busy[write_reg_addr] on the edge, i.e. when the register file commits.
  - Same-edge set and clear of the same register: set wins (a new writer is in flight).
  - Single outstanding writer per register is guaranteed by the issue side and is not checked here.
- Queries:
  - rsN_busy = busy[rsN_addr], combinational.
  - A register whose clear happens at the current edge still reads busy during that cycle.
  - Address 0 always reads 0.
- count is a registered state output and reflects the occupancy after the most recent edge.

Decomposition:
- Shared package (regfile-side):
  - XLEN = 32, AW = 5, NREGS = 32
  - A packed result-entry typedef {rd[AW-1:0], data[XLEN-1:0]}
- Sub-module rf_wb_fifo: generic DEPTH-entry synchronous FIFO with async active-low reset, count output, push/pop.
- The scoreboard and write-port registers live in the top module.

Test Plan:
- Reset mid-traffic: enqueue 3 results with wb_hold=1, reserve x5, pull rst_n low -> count=0, write_ena=0, rs1_busy=0 for rs1_addr=5 immediately, without waiting for a clock edge.
- Basic latency: queue empty, issue x7, push {rd=7, data=0xDEADBEEF} at edge N -> write_ena=1, write_reg_addr=7, data_in=0xDEADBEEF during the cycle after edge N+1. busy[7] reads 1 until edge N+2, then 0.
- Full/backpressure: wb_hold=1, push 4 results -> count=4, res_ready=0. A 5th res_valid is not accepted. Release wb_hold -> 4 writes in push order on consecutive cycles, and res_ready=1 after the first pop.
- x0 handling: push {rd=0, data=0x1234} and issue_rd=0 -> accepted, count unchanged, no write_ena pulse, rs1_busy=0 for rs1_addr=0.
- Set/clear collision: x9 pending with its write committing at edge M, issue_valid with issue_rd=9 at the same edge M -> busy[9] remains 1 after edge M.
- Simultaneous push/pop with wrap: count=2, pointers near wrap, push and pop every cycle for 8 cycles -> count stays 2, write sequence matches push sequence exactly, no entry lost or duplicated.
